reg12_arbiter: RTL and testbench

REG12_ARBITER -- requirements
Module: reg12_arbiter

---
 rtl/reg12_arbiter.sv | 134 +++++++++++++
 tb/tb_reg12_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/reg12_arbiter.sv
// Round-robin arbiter granting three requesters bounded ownership
// of a shared 12-bit register, with a release gap between owners.
module reg12_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [11:0] d0,
    input  logic [11:0] d1,
    input  logic [11:0] d2,
    output logic [2:0]  grant,
    output logic [11:0] q,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        REL  = 2'd2
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(HOLD_MAX - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_last;
    logic [1:0]  r_own;
    logic [2:0]  r_grant;
    logic [11:0] r_q;
    logic        r_busy;

    logic [1:0]  w_o0;
    logic [1:0]  w_o1;
    logic [1:0]  w_o2;
    logic [1:0]  w_win;
    logic        w_wr;
    logic [11:0] w_wd;
    logic        w_done;

    // search order starts just after the previous owner
    always_comb begin
        w_o0 = 2'd0;
        w_o1 = 2'd1;
        w_o2 = 2'd2;
        unique case (r_last)
            2'd0: begin
                w_o0 = 2'd1;
                w_o1 = 2'd2;
                w_o2 = 2'd0;
            end
            2'd1: begin
                w_o0 = 2'd2;
                w_o1 = 2'd0;
                w_o2 = 2'd1;
            end
            default: begin
                w_o0 = 2'd0;
                w_o1 = 2'd1;
                w_o2 = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_win = w_o2;
        if (req[w_o0])
            w_win = w_o0;
        else if (req[w_o1])
            w_win = w_o1;
    end

    always_comb begin
        w_wr = |(r_grant & we);
        w_wd = d2;
        unique case (1'b1)
            r_grant[0]: w_wd = d0;
            r_grant[1]: w_wd = d1;
            default:    w_wd = d2;
        endcase
    end

    assign w_done = !req[r_own] || (r_cnt == LP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_last  <= 2'd2;
            r_own   <= 2'd0;
            r_grant <= 3'b000;
            r_busy  <= 1'b0;
            r_q     <= 12'h000;
        end else begin
            if (w_wr)
                r_q <= w_wd;
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state <= OWN;
                        r_own   <= w_win;
                        r_grant <= 3'b001 << w_win;
                        r_busy  <= 1'b1;
                        r_cnt   <= 4'd0;
                    end
                end
                OWN: begin
                    if (w_done) begin
                        r_state <= REL;
                        r_grant <= 3'b000;
                        r_busy  <= 1'b0;
                        r_last  <= r_own;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                REL: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 3'b000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign q     = r_q;
    assign busy  = r_busy;

endmodule

// File: tb/tb_reg12_arbiter.sv
// Bench for reg12_arbiter: directed scenarios plus random traffic
// checked each cycle against a behavioural ownership model.
module tb_reg12_arbiter;

    localparam int HOLD = 8;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [11:0] d0;
    logic [11:0] d1;
    logic [11:0] d2;
    logic [2:0]  grant;
    logic [11:0] q;
    logic        busy;

    int n_chk;
    int n_fail;

    int          m_own;
    int          m_held;
    int          m_last;
    int          m_cool;
    logic [11:0] m_q;

    reg12_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .d0    (d0),
        .d1    (d1),
        .d2    (d2),
        .grant (grant),
        .q     (q),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rs, input logic [2:0] rq,
                              input logic [2:0] wr,
                              input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c);
        logic [11:0] dd [3];
        dd[0] = a;
        dd[1] = b;
        dd[2] = c;
        if (rs) begin
            m_q    = 12'h000;
            m_own  = -1;
            m_held = 0;
            m_last = 2;
            m_cool = 0;
        end else if (m_own >= 0) begin
            if (wr[m_own])
                m_q = dd[m_own];
            m_held++;
            if (!rq[m_own] || m_held == HOLD) begin
                m_last = m_own;
                m_own  = -1;
                m_cool = 1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (rq != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (m_own < 0 && rq[idx]) begin
                    m_own  = idx;
                    m_held = 0;
                end
            end
        end
    endtask

    task automatic step(input logic rs, input logic [2:0] rq,
                        input logic [2:0] wr,
                        input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] c);
        logic [2:0] eg;
        reset = rs;
        req   = rq;
        we    = wr;
        d0    = a;
        d1    = b;
        d2    = c;
        @(posedge clk);
        model_edge(rs, rq, wr, a, b, c);
        #1;
        eg = (m_own < 0) ? 3'b000 : 3'(1 << m_own);
        check("grant", 32'(grant), 32'(eg));
        check("q", 32'(q), 32'(m_q));
        check("busy", 32'(busy), 32'(m_own >= 0));
        check("onehot", 32'($countones(grant) <= 1), 32'd1);
    endtask

    initial begin
        logic [2:0] g [40];
        logic [2:0] rq;
        int cnt;
        clk    = 1'b0;
        reset  = 1'b1;
        req    = 3'b000;
        we     = 3'b000;
        d0     = 12'h000;
        d1     = 12'h000;
        d2     = 12'h000;
        n_chk  = 0;
        n_fail = 0;
        m_own  = -1;
        m_held = 0;
        m_last = 2;
        m_cool = 0;
        m_q    = 12'h000;

        // reset state, then all three requesting
        step(1, 3'b000, 3'b111, 12'h111, 12'h222, 12'h333);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            step(0, 3'b111, 3'b000, 12'h0, 12'h0, 12'h0);
            g[i] = grant;
        end
        for (int i = 0; i < 40; i++) begin
            logic [2:0] e;
            e = ((i % 10) < 8) ? 3'(1 << ((i / 10) % 3)) : 3'b000;
            check("rr_seq", 32'(g[i]), 32'(e));
        end

        // owner write, non-owner write ignored
        step(1, 3'b000, 3'b000, 12'h0, 12'h0, 12'h0);
        step(0, 3'b001, 3'b011, 12'hABC, 12'h123, 12'h0);
        step(0, 3'b001, 3'b011, 12'hABC, 12'h123, 12'h0);
        check("wr_owner", 32'(q), 32'hABC);

        // voluntary release with write on final grant cycle
        step(1, 3'b000, 3'b000, 12'h0, 12'h0, 12'h0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 3'b010, 3'b000, 12'h0, 12'h0, 12'h0);
            if (grant == 3'b010) cnt++;
        end
        step(0, 3'b000, 3'b010, 12'h0, 12'h5A5, 12'h0);
        check("vol_rel_grant", 32'(grant), 32'd0);
        check("vol_rel_q", 32'(q), 32'h5A5);
        check("vol_len", 32'(cnt), 32'd3);

        // forced release at HOLD_MAX, regrant after gap
        step(1, 3'b000, 3'b000, 12'h0, 12'h0, 12'h0);
        step(0, 3'b100, 3'b100, 12'h0, 12'h0, 12'hFFF);
        cnt = 1;
        for (int k = 0; k < 8; k++) begin
            step(0, 3'b100, 3'b100, 12'h0, 12'h0, 12'(k));
            if (grant == 3'b100) cnt++;
        end
        check("hold_len", 32'(cnt), 32'd8);
        check("hold_q", 32'(q), 32'h7);
        step(0, 3'b100, 3'b100, 12'h0, 12'h0, 12'h8);
        check("gap_idle", 32'(grant), 32'd0);
        step(0, 3'b100, 3'b100, 12'h0, 12'h0, 12'h9);
        check("regrant", 32'(grant), 32'b100);
        check("gap_q", 32'(q), 32'h7);

        // reset mid-ownership overrides a write
        step(1, 3'b000, 3'b000, 12'h0, 12'h0, 12'h0);
        step(0, 3'b001, 3'b000, 12'hFFF, 12'h0, 12'h0);
        step(1, 3'b001, 3'b001, 12'hFFF, 12'h0, 12'h0);
        check("rst_mid_q", 32'(q), 32'd0);
        check("rst_mid_grant", 32'(grant), 32'd0);
        step(0, 3'b111, 3'b000, 12'h0, 12'h0, 12'h0);
        check("rst_first", 32'(grant), 32'b001);

        // random traffic
        rq = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 3; b++)
                if ($urandom_range(3) == 0) rq[b] = ~rq[b];
            step(($urandom_range(59) == 0), rq, 3'($urandom),
                 12'($urandom), 12'($urandom), 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
